// File: rtl/sb_cfg_credit_tx_agent.sv
// Sideband RDI config credit-loop TX agent (adapter side).
//
// Serializes 64-bit header (+ optional 64-bit payload) config messages onto the
// NC-bit lp_cfg lanes, LSB slice first, gated by a TX credit counter that the PHY
// replenishes with i_pl_cfg_crd pulses. Also returns lp_cfg credits to the PHY,
// one o_lp_cfg_crd pulse per received pl_cfg message the adapter has drained.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_msg_vld/o_msg_rdy  local message handshake (o_msg_rdy is combinational)
//   i_msg_hdr/_data      message header / payload, i_msg_has_data selects payload
//   o_lp_cfg/_vld        config lane beat toward the PHY (0 when idle)
//   i_pl_cfg_crd         PHY returns one TX credit
//   i_rx_msg_done        adapter consumed one received message
//   o_lp_cfg_crd         one pulse per credit returned to the PHY
//   o_crd_avail          current TX credit count
//   o_crd_overflow       sticky: credit received at full count or return counter saturated
module sb_cfg_credit_tx_agent #(
    parameter int unsigned NC      = 32,
    parameter int unsigned MAX_CRD = 32,
    parameter int unsigned CRD_W   = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_msg_vld,
    output logic             o_msg_rdy,
    input  logic [63:0]      i_msg_hdr,
    input  logic [63:0]      i_msg_data,
    input  logic             i_msg_has_data,
    output logic [NC-1:0]    o_lp_cfg,
    output logic             o_lp_cfg_vld,
    input  logic             i_pl_cfg_crd,
    input  logic             i_rx_msg_done,
    output logic             o_lp_cfg_crd,
    output logic [CRD_W-1:0] o_crd_avail,
    output logic             o_crd_overflow
);

    localparam int unsigned NBeats = 64 / NC;
    localparam int unsigned BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);
    localparam logic [CRD_W-1:0] CrdMax   = CRD_W'(MAX_CRD);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e             state_q, state_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [63:0]        hdr_q, hdr_d;
    logic [63:0]        data_q, data_d;
    logic               has_data_q, has_data_d;
    logic [NC-1:0]      lp_cfg_q, lp_cfg_d;
    logic               lp_cfg_vld_q, lp_cfg_vld_d;
    logic [CRD_W-1:0]   crd_q, crd_d;
    logic [CRD_W-1:0]   pend_q, pend_d;
    logic               lp_cfg_crd_q, lp_cfg_crd_d;
    logic               ovf_q, ovf_d;

    logic               last_beat;
    logic               msg_rdy;
    logic               accept;
    logic               emit;
    logic [BeatW-1:0]   next_beat;

    // The final beat of a message is on the lanes this cycle; a new message may be
    // accepted now so its first beat follows with no gap.
    assign last_beat = (state_q == StHdr && beat_q == LastBeat && !has_data_q) ||
                       (state_q == StData && beat_q == LastBeat);
    assign msg_rdy   = !i_rst && (crd_q != '0) && (state_q == StIdle || last_beat);
    assign accept    = i_msg_vld && msg_rdy;
    assign next_beat = beat_q + 1'b1;
    assign emit      = (pend_q != '0);

    // Serializer FSM: lp_cfg_q always holds the beat selected by (state_q, beat_q).
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        hdr_d        = hdr_q;
        data_d       = data_q;
        has_data_d   = has_data_q;
        lp_cfg_d     = '0;
        lp_cfg_vld_d = 1'b0;
        if (accept) begin
            state_d      = StHdr;
            beat_d       = '0;
            hdr_d        = i_msg_hdr;
            data_d       = i_msg_has_data ? i_msg_data : '0;
            has_data_d   = i_msg_has_data;
            lp_cfg_d     = i_msg_hdr[NC-1:0];
            lp_cfg_vld_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StHdr: begin
                    if (beat_q != LastBeat) begin
                        beat_d       = next_beat;
                        lp_cfg_d     = hdr_q[NC*int'(next_beat) +: NC];
                        lp_cfg_vld_d = 1'b1;
                    end else if (has_data_q) begin
                        state_d      = StData;
                        beat_d       = '0;
                        lp_cfg_d     = data_q[NC-1:0];
                        lp_cfg_vld_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (beat_q != LastBeat) begin
                        beat_d       = next_beat;
                        lp_cfg_d     = data_q[NC*int'(next_beat) +: NC];
                        lp_cfg_vld_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // TX credits and RX credit return.
    always_comb begin
        crd_d        = crd_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        lp_cfg_crd_d = emit;

        // Accept and replenish in the same cycle cancel out.
        if (accept && !i_pl_cfg_crd) begin
            crd_d = crd_q - 1'b1;
        end else if (!accept && i_pl_cfg_crd) begin
            if (crd_q >= CrdMax) begin
                ovf_d = 1'b1;
            end else begin
                crd_d = crd_q + 1'b1;
            end
        end

        if (i_rx_msg_done && !emit) begin
            if (pend_q >= CrdMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (emit && !i_rx_msg_done) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            hdr_q        <= '0;
            data_q       <= '0;
            has_data_q   <= 1'b0;
            lp_cfg_q     <= '0;
            lp_cfg_vld_q <= 1'b0;
            crd_q        <= CrdMax;
            pend_q       <= '0;
            lp_cfg_crd_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            hdr_q        <= hdr_d;
            data_q       <= data_d;
            has_data_q   <= has_data_d;
            lp_cfg_q     <= lp_cfg_d;
            lp_cfg_vld_q <= lp_cfg_vld_d;
            crd_q        <= crd_d;
            pend_q       <= pend_d;
            lp_cfg_crd_q <= lp_cfg_crd_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_msg_rdy      = msg_rdy;
    assign o_lp_cfg       = lp_cfg_q;
    assign o_lp_cfg_vld   = lp_cfg_vld_q;
    assign o_lp_cfg_crd   = lp_cfg_crd_q;
    assign o_crd_avail    = crd_q;
    assign o_crd_overflow = ovf_q;

endmodule

// File: tb/tb_sb_cfg_credit_tx_agent.sv
module tb_sb_cfg_credit_tx_agent;

    localparam int NC      = 32;
    localparam int MAX_CRD = 32;
    localparam int CRD_W   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             msg_vld;
    logic             msg_rdy;
    logic [63:0]      msg_hdr;
    logic [63:0]      msg_data;
    logic             msg_has_data;
    logic [NC-1:0]    lp_cfg;
    logic             lp_cfg_vld;
    logic             pl_cfg_crd;
    logic             rx_msg_done;
    logic             lp_cfg_crd;
    logic [CRD_W-1:0] crd_avail;
    logic             crd_overflow;

    always #5 clk = ~clk;

    sb_cfg_credit_tx_agent #(
        .NC      (NC),
        .MAX_CRD (MAX_CRD),
        .CRD_W   (CRD_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_msg_vld      (msg_vld),
        .o_msg_rdy      (msg_rdy),
        .i_msg_hdr      (msg_hdr),
        .i_msg_data     (msg_data),
        .i_msg_has_data (msg_has_data),
        .o_lp_cfg       (lp_cfg),
        .o_lp_cfg_vld   (lp_cfg_vld),
        .i_pl_cfg_crd   (pl_cfg_crd),
        .i_rx_msg_done  (rx_msg_done),
        .o_lp_cfg_crd   (lp_cfg_crd),
        .o_crd_avail    (crd_avail),
        .o_crd_overflow (crd_overflow)
    );

    logic [NC-1:0] exp_q[$];
    logic [NC-1:0] exp_beat;
    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;
    int cyc         = 0;
    int beat_cnt    = 0;
    int first_cyc   = 0;
    int last_cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid beat must match the oldest expected beat; idle lanes must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (lp_cfg_vld === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got %h, required no beat", lp_cfg);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (lp_cfg !== exp_beat) begin
                        miscompares++;
                        $display("FAIL beat_data: got %h, required %h", lp_cfg, exp_beat);
                    end
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
            end else if (lp_cfg_vld !== 1'b0 || lp_cfg !== '0) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_lane: vld=%b data=%h, required vld=0 data=0", lp_cfg_vld,
                         lp_cfg);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [63:0] hdr, input logic [63:0] data, input bit hd);
        for (int i = 0; i < 64 / NC; i++) exp_q.push_back(hdr[NC*i +: NC]);
        if (hd) for (int i = 0; i < 64 / NC; i++) exp_q.push_back(data[NC*i +: NC]);
    endtask

    // Returns one posedge+1 after the accepting edge.
    task automatic send_msg(input logic [63:0] hdr, input logic [63:0] data, input bit hd);
        int n;
        msg_vld      = 1'b1;
        msg_hdr      = hdr;
        msg_data     = data;
        msg_has_data = hd;
        n = 0;
        forever begin
            @(negedge clk);
            if (msg_rdy === 1'b1) break;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: msg_rdy=%b, required 1 within 200 cycles", msg_rdy);
                break;
            end
        end
        if (n <= 200) push_beats(hdr, data, hd);
        align();
        msg_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && lp_cfg_vld === 1'b0) break;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: %0d beats pending, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        align();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        align();
        align();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        msg_vld = 1'b0; msg_hdr = '0; msg_data = '0; msg_has_data = 1'b0;
        pl_cfg_crd = 1'b0; rx_msg_done = 1'b0;
        align();
        align();
        mon_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (msg_rdy !== 1'b0 || lp_cfg_vld !== 1'b0 || lp_cfg !== '0 || lp_cfg_crd !== 1'b0 ||
            crd_avail !== 6'd32 || crd_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b cfg=%h crd=%b avail=%0d ovf=%b, required 0 0 0 0 32 0",
                     msg_rdy, lp_cfg_vld, lp_cfg, lp_cfg_crd, crd_avail, crd_overflow);
        end
        align();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (msg_rdy !== 1'b1 || crd_avail !== 6'd32) begin
            miscompares++;
            $display("FAIL post_reset: rdy=%b avail=%0d, required 1 32", msg_rdy, crd_avail);
        end
        align();
    endtask

    task automatic test_hdr_only();
        send_msg(64'h1111_2222_3333_4444, 64'h0, 1'b0);
        @(negedge clk);
        vectors++;
        if (lp_cfg_vld !== 1'b1 || lp_cfg !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL hdr_beat0_timing: vld=%b data=%h, required 1 33334444", lp_cfg_vld, lp_cfg);
        end
        @(negedge clk);
        vectors++;
        if (lp_cfg_vld !== 1'b1 || lp_cfg !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL hdr_beat1_timing: vld=%b data=%h, required 1 11112222", lp_cfg_vld, lp_cfg);
        end
        wait_drain();
        vectors++;
        if (crd_avail !== 6'd31) begin
            miscompares++;
            $display("FAIL hdr_only_credit: got %0d, required 31", crd_avail);
        end
    endtask

    task automatic test_data_msg();
        logic exp_rdy;
        send_msg(64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_rdy = (k == 3);
            vectors++;
            if (msg_rdy !== exp_rdy || lp_cfg_vld !== 1'b1) begin
                miscompares++;
                $display("FAIL data_msg_rdy beat%0d: rdy=%b vld=%b, required rdy=%b vld=1",
                         k, msg_rdy, lp_cfg_vld, exp_rdy);
            end
        end
        wait_drain();
        vectors++;
        if (crd_avail !== 6'd30) begin
            miscompares++;
            $display("FAIL data_msg_credit: got %0d, required 30", crd_avail);
        end
    endtask

    task automatic test_back_to_back();
        beat_cnt = 0;
        send_msg(64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0);
        send_msg(64'hDEAD_BEEF_0000_0002, 64'h0, 1'b0);
        send_msg(64'hDEAD_BEEF_0000_0003, 64'h0, 1'b0);
        wait_drain();
        vectors++;
        if (beat_cnt != 6 || last_cyc - first_cyc != 5) begin
            miscompares++;
            $display("FAIL back_to_back_gap: beats=%0d span=%0d, required 6 beats over 6 cycles",
                     beat_cnt, last_cyc - first_cyc + 1);
        end
        vectors++;
        if (crd_avail !== 6'd27) begin
            miscompares++;
            $display("FAIL back_to_back_credit: got %0d, required 27", crd_avail);
        end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        for (int i = 0; i < MAX_CRD; i++) send_msg(64'(i) | 64'hA5A5_0000_0000_0000, 64'h0, 1'b0);
        wait_drain();
        vectors++;
        if (crd_avail !== 6'd0 || msg_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL exhaust_state: avail=%0d rdy=%b, required 0 0", crd_avail, msg_rdy);
        end
        msg_vld = 1'b1; msg_hdr = 64'h3333_0000_3333_FFFF; msg_has_data = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (msg_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL exhaust_hold%0d: rdy=%b, required 0", k, msg_rdy);
            end
        end
        align();
        pl_cfg_crd = 1'b1;
        align();
        pl_cfg_crd = 1'b0;
        @(negedge clk);
        vectors++;
        if (msg_rdy !== 1'b1 || crd_avail !== 6'd1) begin
            miscompares++;
            $display("FAIL exhaust_refill: rdy=%b avail=%0d, required 1 1", msg_rdy, crd_avail);
        end
        push_beats(msg_hdr, 64'h0, 1'b0);
        align();
        msg_vld = 1'b0;
        wait_drain();
        vectors++;
        if (crd_avail !== 6'd0) begin
            miscompares++;
            $display("FAIL exhaust_after_send: avail=%0d, required 0", crd_avail);
        end
    endtask

    task automatic test_credit_simul_and_overflow();
        do_reset();
        for (int i = 0; i < MAX_CRD - 5; i++) send_msg(64'h5555_0000_0000_0000 + 64'(i), 64'h0, 1'b0);
        wait_drain();
        msg_vld = 1'b1; msg_hdr = 64'h0BAD_F00D_1234_5678; msg_has_data = 1'b0;
        pl_cfg_crd = 1'b1;
        @(negedge clk);
        vectors++;
        if (msg_rdy !== 1'b1 || crd_avail !== 6'd5) begin
            miscompares++;
            $display("FAIL simul_pre: rdy=%b avail=%0d, required 1 5", msg_rdy, crd_avail);
        end
        push_beats(msg_hdr, 64'h0, 1'b0);
        align();
        msg_vld = 1'b0; pl_cfg_crd = 1'b0;
        @(negedge clk);
        vectors++;
        if (crd_avail !== 6'd5 || crd_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_credit: avail=%0d ovf=%b, required 5 0", crd_avail, crd_overflow);
        end
        wait_drain();
        do_reset();
        pl_cfg_crd = 1'b1;
        align();
        pl_cfg_crd = 1'b0;
        @(negedge clk);
        vectors++;
        if (crd_avail !== 6'd32 || crd_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: avail=%0d ovf=%b, required 32 1", crd_avail, crd_overflow);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (crd_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", crd_overflow);
        end
        align();
        do_reset();
        @(negedge clk);
        vectors++;
        if (crd_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: ovf=%b, required 0", crd_overflow);
        end
        align();
    endtask

    task automatic test_crd_return();
        logic [6:0] exp_pat;
        logic       exp_bit;
        exp_pat = 7'b0001110;  // bit k: sample after the (k+1)th edge
        rx_msg_done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            align();
            if (k == 2) rx_msg_done = 1'b0;
            @(negedge clk);
            exp_bit = exp_pat[k];
            vectors++;
            if (lp_cfg_crd !== exp_bit) begin
                miscompares++;
                $display("FAIL crd_return cycle%0d: got %b, required %b", k, lp_cfg_crd, exp_bit);
            end
        end
        align();
    endtask

    task automatic test_reset_mid();
        send_msg(64'hFEED_FACE_CAFE_BABE, 64'h1234_5678_9ABC_DEF0, 1'b1);
        align();
        rst = 1'b1;
        align();
        exp_q.delete();
        rst = 1'b0;
        vectors++;
        if (lp_cfg_vld !== 1'b0 || lp_cfg !== '0 || crd_avail !== 6'd32) begin
            miscompares++;
            $display("FAIL reset_mid: vld=%b cfg=%h avail=%0d, required 0 0 32",
                     lp_cfg_vld, lp_cfg, crd_avail);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (lp_cfg_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_beats cycle%0d: vld=%b, required 0", k, lp_cfg_vld);
            end
        end
        align();
    endtask

    initial begin
        test_reset();
        test_hdr_only();
        test_data_msg();
        test_back_to_back();
        test_credit_exhaust();
        test_credit_simul_and_overflow();
        test_crd_return();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sb_cfg_credit_tx_agent.md
Name: sb_cfg_credit_tx_agent

Overview:
- Adapter-side peer of the sideband RDI config credit loop.
- Serializes locally generated sideband config messages onto the lp_cfg lanes, gated by a credit counter that i_pl_cfg_crd replenishes.
- Returns lp_cfg credits to the PHY as the adapter drains received pl_cfg messages.
- Sits between the adapter sideband message generator/consumer and the RDI config interface.

Parameters:
- NC, 32, lp_cfg lane width in bits; legal values 16, 32, 64.
- MAX_CRD, 32, credits the PHY advertises at reset; maximum outstanding messages.
- CRD_W, 6, width of the credit counters; must hold MAX_CRD.

Ports:
- i_clk  in  1  block clock.
- i_rst  in  1  synchronous reset, active-high.
- i_msg_vld  in  1  local message valid.
- o_msg_rdy  out  1  block accepts a message this cycle.
- i_msg_hdr  in  64  message header.
- i_msg_data  in  64  message payload; used only when i_msg_has_data=1.
- i_msg_has_data  in  1  message carries a 64-bit payload.
- o_lp_cfg  out  NC  config lane data toward the PHY.
- o_lp_cfg_vld  out  1  o_lp_cfg carries a valid beat.
- i_pl_cfg_crd  in  1  one-cycle pulse; returns one credit from the PHY.
- i_rx_msg_done  in  1  one-cycle pulse; adapter consumed one received pl_cfg message.
- o_lp_cfg_crd  out  1  high for one cycle per credit returned to the PHY.
- o_crd_avail  out  CRD_W  current TX credit count.
- o_crd_overflow  out  1  sticky error flag.

Behaviour:
- Reset values (i_rst=1 at a clock edge): o_msg_rdy=0, o_lp_cfg=0, o_lp_cfg_vld=0, o_lp_cfg_crd=0, o_crd_avail=MAX_CRD, o_crd_overflow=0, pending-return count=0, FSM=IDLE.
- All outputs are registered, except o_msg_rdy, which is combinational from state and credit count.
- FSM states:
  - IDLE: o_msg_rdy = (crd_cnt != 0). On i_msg_vld & o_msg_rdy: latch hdr, data and has_data; decrement crd_cnt; go to HDR with beat index 0.
  - HDR: drive header beats, least-significant NC bits first. There are 64/NC beats, with o_lp_cfg_vld=1 on each. After the last header beat, go to DATA if has_data, otherwise IDLE.
  - DATA: drive 64/NC payload beats, LSB first, then go to IDLE.
- Latency and timing:
  - The message is accepted in cycle N; its first beat appears on o_lp_cfg in cycle N+1.
  - Beats are back-to-back with no stall; the lp_cfg interface has no backpressure beyond credits.
  - o_msg_rdy=0 in HDR and DATA.
  - The next message can be accepted in the cycle the last beat is driven. Its first beat follows immediately, so there are zero idle cycles between messages.
- Beat counts: with NC=64, a header-only message is 1 beat and a message with data is 2 beats. With NC=16, the counts are 4 and 8.
- o_lp_cfg_vld=0 and o_lp_cfg holds 0 whenever no beat is driven.
- TX credit counter:
  - Accept alone: -1.
  - i_pl_cfg_crd alone: +1.
  - Both in the same cycle: unchanged.
  - Accept is impossible at 0, so there is no underflow.
  - i_pl_cfg_crd while the count is already MAX_CRD (with no simultaneous accept): the count stays at MAX_CRD and o_crd_overflow sets the next cycle, remaining set until reset.
- Credit return path:
  - The pending counter increments on i_rx_msg_done.
  - Each cycle pending != 0, the next cycle has o_lp_cfg_crd=1 and the pending count drops by 1. Pulses may be consecutive.
  - i_rx_msg_done together with an emit: the count is unchanged.
  - The pending count saturates at MAX_CRD. An i_rx_msg_done at saturation without an emit also sets o_crd_overflow.
- Reset mid-message: the in-flight message is dropped with no further beats, credits are restored to MAX_CRD, and pending returns are cleared.

Test Plan:
- After reset, with NC=32: o_crd_avail=32 and o_msg_rdy=1. Send a header-only message with hdr=0x1111_2222_3333_4444 -> beats 0x33334444 then 0x11112222 in cycles N+1 and N+2; o_crd_avail=31.
- Send a message with data, hdr=H, data=0xAAAA_BBBB_CCCC_DDDD -> 4 consecutive beats: H[31:0], H[63:32], 0xCCCCDDDD, 0xAAAABBBB. o_msg_rdy stays low until the last beat.
- Send 32 messages with no i_pl_cfg_crd -> o_crd_avail=0 and o_msg_rdy=0, and a 33rd i_msg_vld is held. One i_pl_cfg_crd pulse -> o_msg_rdy=1 next cycle, and the message is sent.
- At o_crd_avail=5, assert accept and i_pl_cfg_crd in the same cycle -> 5 remains. At 32, pulse i_pl_cfg_crd -> count stays 32 and o_crd_overflow=1 persists.
- Pulse i_rx_msg_done on 3 consecutive cycles -> o_lp_cfg_crd high for exactly 3 consecutive cycles starting one cycle later.
- Assert i_rst during the second beat of a 4-beat message -> o_lp_cfg_vld=0 next cycle, o_crd_avail=32, no further beats.
